// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the MMIO bridge: default device bases and window sizes.
package mmio_bridge_pkg;

  localparam logic [31:0] DEV0_BASE_DFLT = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE_DFLT = 32'h0000_7F10;
  localparam logic [31:0] MMIO_BASE_DFLT = 32'h0000_7F00;

  localparam int unsigned DEV_WIN_WORDS  = 3;
  localparam logic [31:0] DEV_WIN_BYTES  = 32'(DEV_WIN_WORDS * 4);
  localparam logic [31:0] MMIO_WIN_BYTES = 32'd256;

  // True when addr lies in [base, base+size); written without base+size to avoid wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/mmio_bridge_byte_merge.sv
// Per-lane byte mux: enabled lanes take the new word, the rest keep the old word.
module mmio_bridge_byte_merge
  import mmio_bridge_pkg::*;
(
  input  logic [3:0]  byte_en_i,
  input  logic [31:0] new_word_i,
  input  logic [31:0] old_word_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    for (int n = 0; n < 4; n++) begin
      if (byte_en_i[n]) merged_o[8*n +: 8] = new_word_i[8*n +: 8];
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-timer MMIO bridge: address decode, read mux, write strobes,
// partial-store merge and a sticky flag for stores into unmapped MMIO space.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DFLT,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DFLT,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] BRG_i_Addr,
  input  logic [3:0]  BRG_i_ByteEnable,
  input  logic [31:0] BRG_i_WData_shifted,
  input  logic        BRG_i_WEnable,
  input  logic [31:0] BRG_i_DEV0_RData,
  input  logic [31:0] BRG_i_DEV1_RData,
  output logic [31:0] BRG_o_RData,
  output logic [31:0] BRG_o_Dev_Addr,
  output logic        BRG_o_Dev0_WEnable,
  output logic        BRG_o_Dev1_WEnable,
  output logic [31:0] BRG_o_Dev_WData,
  output logic        BRG_o_Fault
);

  logic [31:0] word_addr;
  logic        hit0;
  logic        hit1;
  logic        in_mmio;
  logic        fault_set;
  logic [31:0] sel_rdata;
  logic        fault_q;
  logic        fault_d;
  logic [1:0]  unused_addr_lsbs;

  assign word_addr        = {BRG_i_Addr[31:2], 2'b00};
  assign unused_addr_lsbs = BRG_i_Addr[1:0];

  assign hit0    = in_window(word_addr, DEV0_BASE, DEV_WIN_BYTES);
  assign hit1    = in_window(word_addr, DEV1_BASE, DEV_WIN_BYTES);
  assign in_mmio = in_window(word_addr, MMIO_BASE, MMIO_WIN_BYTES);

  // With no hit the old word is zero, so unselected lanes merge to zero.
  always_comb begin
    sel_rdata = 32'h0;
    if (hit0)      sel_rdata = BRG_i_DEV0_RData;
    else if (hit1) sel_rdata = BRG_i_DEV1_RData;
  end

  mmio_bridge_byte_merge u_byte_merge (
    .byte_en_i  (BRG_i_ByteEnable),
    .new_word_i (BRG_i_WData_shifted),
    .old_word_i (sel_rdata),
    .merged_o   (BRG_o_Dev_WData)
  );

  assign BRG_o_RData        = sel_rdata;
  assign BRG_o_Dev_Addr     = word_addr;
  assign BRG_o_Dev0_WEnable = BRG_i_WEnable & hit0;
  assign BRG_o_Dev1_WEnable = BRG_i_WEnable & hit1;

  assign fault_set = BRG_i_WEnable & in_mmio & ~hit0 & ~hit1;
  assign fault_d   = fault_q | fault_set;

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign BRG_o_Fault = fault_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with hand-computed expected values.
module tb_mmio_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] dev0_rdata;
  logic [31:0] dev1_rdata;
  logic [31:0] rdata;
  logic [31:0] dev_addr;
  logic        dev0_we;
  logic        dev1_we;
  logic [31:0] dev_wdata;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  mmio_bridge dut (
    .clk                 (clk),
    .reset               (reset),
    .BRG_i_Addr          (addr),
    .BRG_i_ByteEnable    (be),
    .BRG_i_WData_shifted (wdata),
    .BRG_i_WEnable       (we),
    .BRG_i_DEV0_RData    (dev0_rdata),
    .BRG_i_DEV1_RData    (dev1_rdata),
    .BRG_o_RData         (rdata),
    .BRG_o_Dev_Addr      (dev_addr),
    .BRG_o_Dev0_WEnable  (dev0_we),
    .BRG_o_Dev1_WEnable  (dev1_we),
    .BRG_o_Dev_WData     (dev_wdata),
    .BRG_o_Fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs between clock edges and let combinational paths settle.
  task automatic drive(input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic w);
    @(negedge clk);
    addr  = a;
    be    = b;
    wdata = d;
    we    = w;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    addr       = 32'h0;
    be         = 4'h0;
    wdata      = 32'h0;
    we         = 1'b0;
    dev0_rdata = 32'h1234_5670;
    dev1_rdata = 32'h89AB_CDEF;

    // Reset state; combinational paths stay live while reset is held.
    edge_settle();
    edge_settle();
    check("reset_fault", {31'd0, fault}, 32'h0);
    drive(32'h0000_7F02, 4'h0, 32'h0, 1'b0);
    check("rdata_in_reset", rdata, 32'h1234_5670);
    @(negedge clk);
    reset = 1'b0;

    // Read decode
    drive(32'h0000_7F02, 4'h0, 32'h0, 1'b0);
    check("rd_rdata", rdata, 32'h1234_5670);
    check("rd_devaddr", dev_addr, 32'h0000_7F00);
    check("rd_we0", {31'd0, dev0_we}, 32'h0);
    check("rd_we1", {31'd0, dev1_we}, 32'h0);
    edge_settle();
    check("rd_fault", {31'd0, fault}, 32'h0);

    // Partial writes to dev0
    drive(32'h0000_7F02, 4'b1010, 32'hDD11_AA88, 1'b1);
    check("wr0_we0", {31'd0, dev0_we}, 32'h1);
    check("wr0_we1", {31'd0, dev1_we}, 32'h0);
    check("wr0_wdata", dev_wdata, 32'hDD34_AA70);
    drive(32'h0000_7F02, 4'b0110, 32'hDD11_AA88, 1'b1);
    check("wr0_lanes", dev_wdata, 32'h1211_AA70);

    // Last dev0 word, and BE=0 still strobes with the unchanged word
    drive(32'h0000_7F08, 4'b0000, 32'hDD11_AA88, 1'b1);
    check("wr0_top_we0", {31'd0, dev0_we}, 32'h1);
    check("wr0_be0_wdata", dev_wdata, 32'h1234_5670);

    // Switch to dev1
    drive(32'h0000_7F12, 4'b0110, 32'hDD11_AA88, 1'b1);
    check("wr1_we1", {31'd0, dev1_we}, 32'h1);
    check("wr1_we0", {31'd0, dev0_we}, 32'h0);
    check("wr1_rdata", rdata, 32'h89AB_CDEF);
    check("wr1_wdata", dev_wdata, 32'h8911_AAEF);
    check("wr1_devaddr", dev_addr, 32'h0000_7F10);
    drive(32'h0000_7F12, 4'b0110, 32'hDD11_AA88, 1'b0);
    check("wr1_off_we0", {31'd0, dev0_we}, 32'h0);
    check("wr1_off_we1", {31'd0, dev1_we}, 32'h0);
    edge_settle();
    check("mapped_no_fault", {31'd0, fault}, 32'h0);

    // Writes outside the MMIO window never fault
    drive(32'h0000_3000, 4'hF, 32'hFFFF_FFFF, 1'b1);
    check("out_rdata", rdata, 32'h0);
    check("out_we0", {31'd0, dev0_we}, 32'h0);
    edge_settle();
    check("out_fault", {31'd0, fault}, 32'h0);
    drive(32'h0000_8000, 4'hF, 32'hFFFF_FFFF, 1'b1);
    edge_settle();
    check("above_fault", {31'd0, fault}, 32'h0);
    drive(32'h0000_7EFC, 4'hF, 32'hFFFF_FFFF, 1'b1);
    edge_settle();
    check("below_fault", {31'd0, fault}, 32'h0);

    // Unmapped write inside the window, just past dev0
    drive(32'h0000_7F0C, 4'b1010, 32'hDD11_AA88, 1'b1);
    check("unm_we0", {31'd0, dev0_we}, 32'h0);
    check("unm_we1", {31'd0, dev1_we}, 32'h0);
    check("unm_rdata", rdata, 32'h0);
    check("unm_wdata", dev_wdata, 32'hDD00_AA00);
    check("unm_fault_pre", {31'd0, fault}, 32'h0);
    edge_settle();
    check("unm_fault_set", {31'd0, fault}, 32'h1);
    drive(32'h0000_7F0C, 4'h0, 32'h0, 1'b0);
    edge_settle();
    edge_settle();
    check("unm_fault_sticky", {31'd0, fault}, 32'h1);
    drive(32'h0000_3000, 4'hF, 32'h0, 1'b1);
    edge_settle();
    check("out_fault_unchanged", {31'd0, fault}, 32'h1);

    // Reset clears the flag
    drive(32'h0000_7F00, 4'h0, 32'h0, 1'b0);
    reset = 1'b1;
    edge_settle();
    check("rst_clear", {31'd0, fault}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset wins over a simultaneous offending write
    drive(32'h0000_7F1C, 4'hF, 32'h0, 1'b1);
    reset = 1'b1;
    edge_settle();
    check("rst_wins", {31'd0, fault}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b0;

    // Top of the MMIO window faults
    drive(32'h0000_7FFC, 4'h1, 32'h0, 1'b1);
    edge_settle();
    check("top_fault", {31'd0, fault}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
